// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the combinational instruction memory,
// buffers fetched words in an in-order queue and hands them to decode over valid/ready.
module instruction_fetch_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        REDIRECT_VALID,
  input  logic [63:0] REDIRECT_PC,
  output logic [63:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR,
  output logic [63:0] INSTR_PC,
  output logic        MISALIGNED,
  output logic [31:0] FETCH_COUNT
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;

  state_t             state, state_next;
  logic [63:0]        pc;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic [63:0]        q_pc   [QUEUE_DEPTH];
  logic [31:0]        q_data [QUEUE_DEPTH];
  logic [63:0]        last_pc;
  logic [31:0]        last_instr;

  logic queue_nonempty, pop, attempt, push, fault_hit, fault_clear;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    queue_nonempty = (count != '0);
    INSTR_VALID    = queue_nonempty & ~REDIRECT_VALID;
    pop            = INSTR_VALID & INSTR_READY;
    // Full queue still accepts a fetch when the head leaves in the same cycle.
    attempt        = (state == ST_RUN) & ENABLE & ~REDIRECT_VALID &
                     ((count < CNT_W'(QUEUE_DEPTH)) | pop);
    push           = attempt & (pc[1:0] == 2'b00);
    fault_hit      = attempt & (pc[1:0] != 2'b00);
    fault_clear    = REDIRECT_VALID & (state == ST_FAULT) & (REDIRECT_PC[1:0] == 2'b00);
    IMEM_ADDR      = pc;
    INSTR          = queue_nonempty ? q_data[head] : last_instr;
    INSTR_PC       = queue_nonempty ? q_pc[head]   : last_pc;
  end

  always_comb begin
    state_next = state;
    if (REDIRECT_VALID) begin
      if (state != ST_FAULT || fault_clear) state_next = ENABLE ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (ENABLE) state_next = ST_RUN;
        ST_RUN:   if (fault_hit) state_next = ST_FAULT;
                  else if (!ENABLE) state_next = ST_IDLE;
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      last_pc     <= '0;
      last_instr  <= '0;
      MISALIGNED  <= 1'b0;
      FETCH_COUNT <= '0;
    end else begin
      state <= state_next;
      if (queue_nonempty) begin
        last_pc    <= q_pc[head];
        last_instr <= q_data[head];
      end
      if (REDIRECT_VALID) begin
        pc    <= REDIRECT_PC;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          pc          <= pc + 64'd4;
          tail        <= ptr_inc(tail);
          FETCH_COUNT <= FETCH_COUNT + 32'd1;
        end
        if (pop) head <= ptr_inc(head);
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
      if (fault_hit)        MISALIGNED <= 1'b1;
      else if (fault_clear) MISALIGNED <= 1'b0;
    end
  end

  // Queue storage carries no reset; count gates every read of it.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_pc[tail]   <= pc;
      q_data[tail] <= IMEM_DATA;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Randomized bench for instruction_fetch_ctrl against a queue-based behavioural model.
module tb_instruction_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h0;
  localparam int unsigned QD     = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic        REDIRECT_VALID = 1'b0;
  logic [63:0] REDIRECT_PC = '0;
  logic [63:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic [31:0] INSTR;
  logic [63:0] INSTR_PC;
  logic        MISALIGNED;
  logic [31:0] FETCH_COUNT;

  instruction_fetch_ctrl #(.RESET_PC(RST_PC), .QUEUE_DEPTH(QD)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE),
    .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .INSTR(INSTR), .INSTR_PC(INSTR_PC),
    .MISALIGNED(MISALIGNED), .FETCH_COUNT(FETCH_COUNT)
  );

  always #5 CLK = ~CLK;

  // Memory word at byte address a holds a/4.
  assign IMEM_DATA = IMEM_ADDR[33:2];

  typedef struct packed { logic [63:0] pc; logic [31:0] data; } entry_t;

  entry_t      mq[$];
  entry_t      m_last;
  logic [63:0] m_pc;
  logic [31:0] m_fc;
  bit          m_mis, m_running, m_faulted;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last    = '0;
    m_pc      = RST_PC;
    m_fc      = '0;
    m_mis     = 1'b0;
    m_running = 1'b0;
    m_faulted = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic rv, input logic [63:0] rpc,
                            input logic rdy);
    bit pop, room;
    if (mq.size() != 0) m_last = mq[0];
    pop = (mq.size() != 0) && !rv && rdy;
    if (rv) begin
      mq.delete();
      m_pc = rpc;
      if (!m_faulted || rpc[1:0] == 2'b00) begin
        m_faulted = 1'b0;
        m_mis     = 1'b0;
        m_running = en;
      end
    end else begin
      room = (mq.size() < QD) || pop;
      if (pop) void'(mq.pop_front());
      if (!m_faulted) begin
        if (m_running && en && room) begin
          if (m_pc[1:0] != 2'b00) begin
            m_faulted = 1'b1;
            m_mis     = 1'b1;
          end else begin
            mq.push_back('{pc: m_pc, data: m_pc[33:2]});
            m_pc = m_pc + 64'd4;
            m_fc = m_fc + 32'd1;
          end
        end
        if (!m_faulted) m_running = en;
      end
    end
  endtask

  task automatic cycle(input logic en, input logic rv, input logic [63:0] rpc, input logic rdy);
    entry_t shown;
    @(negedge CLK);
    ENABLE = en; REDIRECT_VALID = rv; REDIRECT_PC = rpc; INSTR_READY = rdy;
    #1;
    shown = (mq.size() != 0) ? mq[0] : m_last;
    check("instr_valid", 64'(INSTR_VALID), 64'((mq.size() != 0) && !rv));
    check("imem_addr",   IMEM_ADDR, m_pc);
    check("instr",       64'(INSTR), 64'(shown.data));
    check("instr_pc",    INSTR_PC, shown.pc);
    check("misaligned",  64'(MISALIGNED), 64'(m_mis));
    check("fetch_count", 64'(FETCH_COUNT), 64'(m_fc));
    model_step(en, rv, rpc, rdy);
  endtask

  task automatic async_reset();
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("rst_valid",   64'(INSTR_VALID), 64'd0);
    check("rst_addr",    IMEM_ADDR, RST_PC);
    check("rst_instr",   64'(INSTR), 64'd0);
    check("rst_ipc",     INSTR_PC, 64'd0);
    check("rst_mis",     64'(MISALIGNED), 64'd0);
    check("rst_fcount",  64'(FETCH_COUNT), 64'd0);
    ENABLE = 1'b0; REDIRECT_VALID = 1'b0; REDIRECT_PC = '0; INSTR_READY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  function automatic logic [63:0] rand_target();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 64'hFFFF_FFFF_FFFF_FFF8;
    if (r == 1) return {50'd0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
    return {50'd0, 12'($urandom_range(0, 4095)), 2'b00};
  endfunction

  initial begin
    int unsigned rdy_pct;
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Straight-line fetch
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);
    // Backpressure then drain
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    // Redirect while full
    repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 64'h100, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    // Misaligned redirect, fault, recovery
    cycle(1'b1, 1'b1, 64'h102, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 64'h200, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    // Disable with entries queued, then resume
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    // PC wrap past 2^64
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b1);
    async_reset();
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);

    for (int phase = 0; phase < 8; phase++) begin
      rdy_pct = 20 + 10 * int'($urandom_range(0, 8));
      for (int i = 0; i < 400; i++) begin
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, rand_target(),
              $urandom_range(0, 99) < rdy_pct);
      end
      if (phase % 3 == 2) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
